in_button_pio: RTL and testbench

Memory-mapped input port that samples external push-button and coin-switch lines, synchronises and debounces them, and latches rising edges for software to poll or take as an interrupt. It is a slave on the processor's system bus, alongside the output ports that drive the seven-segment displays. It carries the same register-read/write protocol in the opposite data direction: external pins in, CPU reads out.

---
 rtl/in_button_pio.sv | 114 +++++++++++
 tb/tb_in_button_pio.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/in_button_pio.sv
// ============================================================================
// Module   : in_button_pio
// Brief    : Bus-readable input port with synchroniser, optional debounce
//            (IN_PIO_DEBOUNCE_EN) and rising-edge capture with interrupt.
// Revision : 1.0
// ============================================================================
`default_nettype none

module in_button_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [WIDTH-1:0] writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] readdata,
  output logic             irq
);

  localparam logic [1:0] c_addr_data    = 2'd0;
  localparam logic [1:0] c_addr_irqmask = 2'd2;
  localparam logic [1:0] c_addr_edgecap = 2'd3;

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (1 << 20) || WIDTH < 1) begin : g_bad_cfg
    $error("in_button_pio: illegal WIDTH or DEBOUNCE_CYCLES");
  end

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] r_stable_d;
  logic [WIDTH-1:0] r_irqmask;
  logic [WIDTH-1:0] r_edgecap;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_clr;
  logic             w_wr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

`ifdef IN_PIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

  // A level is accepted on the clock the run length would hit DEBOUNCE_CYCLES.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [CNT_W-1:0] r_cnt;
    logic             r_stable;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_cnt    <= '0;
        r_stable <= 1'b0;
      end else if (r_sync2[i] == r_stable) begin
        r_cnt    <= '0;
      end else if (r_cnt == c_cnt_last) begin
        r_cnt    <= '0;
        r_stable <= ~r_stable;
      end else begin
        r_cnt    <= r_cnt + 1'b1;
      end
    end

    assign w_stable[i] = r_stable;
  end
`else
  assign w_stable = r_sync2;
`endif

  assign w_wr   = chipselect & ~write_n;
  assign w_rise = w_stable & ~r_stable_d;
  assign w_clr  = (w_wr && address == c_addr_edgecap) ? writedata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stable_d <= '0;
      r_irqmask  <= '0;
      r_edgecap  <= '0;
    end else begin
      r_stable_d <= w_stable;
      if (w_wr && address == c_addr_irqmask) begin
        r_irqmask <= writedata;
      end
      // A capture on the same edge as a clear keeps the bit set.
      r_edgecap  <= (r_edgecap & ~w_clr) | w_rise;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      c_addr_data:    readdata = w_stable;
      c_addr_irqmask: readdata = r_irqmask;
      c_addr_edgecap: readdata = r_edgecap;
      default:        readdata = '0;
    endcase
  end

  assign irq = |(r_edgecap & r_irqmask);

endmodule

`default_nettype wire

// File: tb/tb_in_button_pio.sv
// ============================================================================
// Module   : tb_in_button_pio
// Brief    : Scoreboard bench for in_button_pio; reads are the output events.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_in_button_pio;

  localparam int WIDTH           = 4;
  localparam int DEBOUNCE_CYCLES = 4;
`ifdef IN_PIO_DEBOUNCE_EN
  localparam int HOLD_UNTIL = 4;
  localparam int SETTLE     = 5;
  localparam int CAP_EDGE   = 6;
`else
  localparam int HOLD_UNTIL = 0;
  localparam int SETTLE     = 2;
  localparam int CAP_EDGE   = 2;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       address = '0;
  logic             chipselect = 1'b0;
  logic             write_n = 1'b1;
  logic [WIDTH-1:0] writedata = '0;
  logic [WIDTH-1:0] in_port = '0;
  logic [WIDTH-1:0] readdata;
  logic             irq;

  in_button_pio #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       addr;
    logic [WIDTH-1:0] data;
    logic             irq;
    string            name;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Monitor: every bus read strobe is an output event to check.
  always @(negedge clk) begin
    if (chipselect && write_n) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_read: addr=%0d data=%b, no expected entry", address, readdata);
      end else begin
        m_e = sb.pop_front();
        if (readdata !== m_e.data || irq !== m_e.irq || address !== m_e.addr) begin
          n_bad++;
          $display("FAIL %s: got addr=%0d data=%b irq=%b, need addr=%0d data=%b irq=%b",
                   m_e.name, address, readdata, irq, m_e.addr, m_e.data, m_e.irq);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [WIDTH-1:0] d, input logic q,
                    input string nm);
    exp_t e;
    e.addr = a; e.data = d; e.irq = q; e.name = nm;
    sb.push_back(e);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    tick();
    chipselect = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [WIDTH-1:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  // in_port was changed just before edge 0; read DATA once per window.
  task automatic watch(input logic [WIDTH-1:0] old_v, input logic [WIDTH-1:0] new_v,
                       input logic q, input string nm);
    for (int i = -1; i <= SETTLE; i++) begin
      if (i <= HOLD_UNTIL)  rd(2'd0, old_v, q, nm);
      else if (i >= SETTLE) rd(2'd0, new_v, q, nm);
      else                  tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    reset = 1'b0;

    rd(2'd0, 4'b0000, 1'b0, "reset_data");
    rd(2'd1, 4'b0000, 1'b0, "reset_addr1");
    rd(2'd2, 4'b0000, 1'b0, "reset_mask");
    rd(2'd3, 4'b0000, 1'b0, "reset_edgecap");

    in_port = 4'b0001;
    repeat (3) tick();
    reset   = 1'b1;
    in_port = 4'b0000;
    tick();
    reset   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd(2'd0, 4'b0000, 1'b0, "midreset_data");
      rd(2'd3, 4'b0000, 1'b0, "midreset_edgecap");
    end

`ifdef IN_PIO_DEBOUNCE_EN
    in_port = 4'b0010;
    repeat (3) rd(2'd0, 4'b0000, 1'b0, "glitch_data");
    in_port = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      rd(2'd0, 4'b0000, 1'b0, "glitch_data");
      rd(2'd3, 4'b0000, 1'b0, "glitch_edgecap");
    end
`else
    in_port = 4'b0001;
    tick();
    in_port = 4'b0000;
    repeat (3) tick();
    rd(2'd0, 4'b0000, 1'b0, "pulse_data");
    rd(2'd3, 4'b0001, 1'b0, "pulse_captured");
    wr(2'd3, 4'b0001);
    rd(2'd3, 4'b0000, 1'b0, "pulse_cleared");
`endif

    in_port = 4'b0100;
    watch(4'b0000, 4'b0100, 1'b0, "press_data");
    rd(2'd3, 4'b0100, 1'b0, "press_edgecap_nomask");
    rd(2'd1, 4'b0000, 1'b0, "addr1_zero");
    wr(2'd2, 4'b0100);
    rd(2'd3, 4'b0100, 1'b1, "press_irq");
    rd(2'd2, 4'b0100, 1'b1, "mask_readback");

    in_port = 4'b0110;
    watch(4'b0100, 4'b0110, 1'b1, "press1_data");
    rd(2'd3, 4'b0110, 1'b1, "edgecap_0110");
    wr(2'd3, 4'b0010);
    rd(2'd3, 4'b0100, 1'b1, "clear_bit1");
    wr(2'd2, 4'b0010);
    rd(2'd3, 4'b0100, 1'b0, "mask_excludes");
    wr(2'd2, 4'b0110);
    rd(2'd3, 4'b0100, 1'b1, "mask_includes");

    in_port = 4'b0010;
    watch(4'b0110, 4'b0010, 1'b1, "release_data");
    rd(2'd3, 4'b0100, 1'b1, "release_no_capture");
    wr(2'd0, 4'b1111);
    wr(2'd1, 4'b1111);
    rd(2'd0, 4'b0010, 1'b1, "write_addr0_ignored");
    rd(2'd1, 4'b0000, 1'b1, "write_addr1_ignored");
    rd(2'd2, 4'b0110, 1'b1, "mask_unchanged");
    wr(2'd3, 4'b0100);
    rd(2'd3, 4'b0000, 1'b0, "clear_bit2");

    in_port = 4'b0110;
    repeat (CAP_EDGE) tick();
    wr(2'd3, 4'b0100);
    rd(2'd3, 4'b0100, 1'b1, "set_beats_clear");
    rd(2'd0, 4'b0110, 1'b1, "repress_data");
    wr(2'd3, 4'b1111);
    rd(2'd3, 4'b0000, 1'b0, "final_clear");

    tick();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, need 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
